// File: rtl/hazard_sequencer.sv
// Pipeline control sequencer for the 5-stage core: load-use stalls, mispredict
// flushes, data-memory wait freezes with timeout, and ECALL-halt draining.
module hazard_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_if_id,
  input  logic [31:0] instruction_id_ex,
  input  logic        mem_read_id_ex,
  input  logic        is_halt_id,
  input  logic        branch_mispredict_ex,
  input  logic        dmem_req_ex_mem,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pipeline_freeze,
  output logic        is_halted,
  output logic        mem_error,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] DRAIN_RELOAD = 4'(DRAIN_CYCLES);
  localparam logic [7:0] WAIT_LAST    = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [3:0]  drain_cnt;
  logic [7:0]  wait_cnt;

  logic [6:0]  opcode_id;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [4:0]  rd_ex;
  logic        rs1_used;
  logic        rs2_used;
  logic        load_use;
  logic        mem_wait;
  logic        halt_accept;
  logic        timeout;

  assign opcode_id = instruction_if_id[6:0];
  assign rs1_id    = instruction_if_id[19:15];
  assign rs2_id    = instruction_if_id[24:20];
  assign rd_ex     = instruction_id_ex[11:7];

  assign rs1_used = !(opcode_id == OP_LUI || opcode_id == OP_AUIPC || opcode_id == OP_JAL);
  assign rs2_used = (opcode_id == OP_REG) || (opcode_id == OP_STORE) || (opcode_id == OP_BRANCH);

  // x0 is never a real dependency, so a load into x0 cannot cause a stall.
  assign load_use = mem_read_id_ex && (rd_ex != 5'd0) &&
                    ((rs1_used && rs1_id == rd_ex) || (rs2_used && rs2_id == rd_ex));

  assign mem_wait    = dmem_req_ex_mem && !dmem_ready;
  assign halt_accept = (state == RUN) && !mem_wait && !branch_mispredict_ex &&
                       !load_use && is_halt_id;
  assign timeout     = (state != HALTED) && mem_wait && (wait_cnt == WAIT_LAST);
  assign is_halted   = (state == HALTED);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_bubble    = 1'b0;
    pipeline_freeze = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_wait) begin
          pipeline_freeze = 1'b1;
          pc_write        = 1'b0;
          if_id_write     = 1'b0;
        end else if (branch_mispredict_ex) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      DRAIN: begin
        pc_write        = 1'b0;
        if_id_write     = 1'b0;
        // A frozen drain cycle holds ID/EX too, so no bubble is inserted then.
        id_ex_bubble    = !mem_wait;
        pipeline_freeze = mem_wait;
      end
      HALTED: begin
        pc_write        = 1'b0;
        if_id_write     = 1'b0;
        pipeline_freeze = 1'b1;
      end
      default: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      drain_cnt   <= DRAIN_RELOAD;
      wait_cnt    <= 8'd0;
      stall_count <= 16'd0;
      mem_error   <= 1'b0;
    end else begin
      if (state != HALTED && !pc_write && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;

      if (state != HALTED && mem_wait)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;

      unique case (state)
        RUN: begin
          if (timeout) begin
            mem_error <= 1'b1;
            state     <= HALTED;
          end else if (halt_accept) begin
            drain_cnt <= DRAIN_RELOAD;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (timeout) begin
            mem_error <= 1'b1;
            state     <= HALTED;
          end else if (!mem_wait) begin
            if (drain_cnt == 4'd1)
              state <= HALTED;
            else
              drain_cnt <= drain_cnt - 4'd1;
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule
